// File: rtl/midi_pkg.sv
// MIDI message types, status-class constants and length/byte-select helpers
// shared by the transmit scheduler and its arbiter.
package midi_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } midi_state_t;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
  } midi_msg_t;

  localparam logic [7:0] MIDI_CHAN_LO   = 8'h80;
  localparam logic [7:0] MIDI_PROG_CHG  = 8'hC0;
  localparam logic [7:0] MIDI_PITCH_BND = 8'hE0;
  localparam logic [7:0] MIDI_SYS_LO    = 8'hF0;
  localparam logic [7:0] MIDI_MTC_QF    = 8'hF1;
  localparam logic [7:0] MIDI_SONG_POS  = 8'hF2;
  localparam logic [7:0] MIDI_SONG_SEL  = 8'hF3;
  localparam logic [7:0] MIDI_RT_LO     = 8'hF8;
  localparam logic [7:0] MIDI_DATA_MASK = 8'h7F;

  // Length in bytes; 0 marks a message without a valid status byte.
  function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd1;
    if (!status[7]) begin
      len = 2'd0;
    end else if (status < MIDI_SYS_LO) begin
      len = (status >= MIDI_PROG_CHG && status < MIDI_PITCH_BND) ? 2'd2 : 2'd3;
    end else if (status == MIDI_SONG_POS) begin
      len = 2'd3;
    end else if (status == MIDI_MTC_QF || status == MIDI_SONG_SEL) begin
      len = 2'd2;
    end
    return len;
  endfunction

  function automatic logic midi_is_chan(input logic [7:0] status);
    return (status >= MIDI_CHAN_LO) && (status < MIDI_SYS_LO);
  endfunction

  function automatic logic [7:0] midi_msg_byte(input midi_msg_t m, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = m.status;
      2'd1:    b = m.data1 & MIDI_DATA_MASK;
      default: b = m.data2 & MIDI_DATA_MASK;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/midi_rr_arbiter.sv
// Round-robin pick of the first asserted request at or above rr_ptr (with wrap).
// Latency: purely combinational; no backpressure of its own.
module midi_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic             found;
  int               pos;
  logic [IDX_W-1:0] pos_w;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    pos_w   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      pos_w = IDX_W'(pos);
      if (!found && req[pos_w]) begin
        found      = 1'b1;
        gnt[pos_w] = 1'b1;
        gnt_idx    = pos_w;
      end
    end
  end

endmodule

// File: rtl/midi_tx_scheduler.sv
// Shares one UART MIDI transmitter among NUM_REQ sources, whole messages only; optional MIDI_RUNNING_STATUS_EN.
// Latency: first byte one cycle after accept; tx_data/tx_valid hold while tx_ready=0, requesters wait while busy.
module midi_tx_scheduler
  import midi_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [24*NUM_REQ-1:0]      req_msg,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [7:0]                 tx_data,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       drop_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  midi_state_t      state, state_d;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] rr_ptr;
  midi_msg_t        acc_msg;
  midi_msg_t        msg_q;
  logic [1:0]       acc_len;
  logic [1:0]       acc_first;
  logic [1:0]       byte_idx;
  logic [1:0]       last_idx;
  logic             accept;
  logic             tx_fire;
  logic             last_byte;
  logic             rs_hit;

  midi_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // reset_n gating keeps req_ready low during reset even before the state flop settles.
  assign req_ready = (state == ST_IDLE && reset_n) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign acc_msg   = req_msg[int'(gnt_idx)*24 +: 24];
  assign acc_len   = midi_msg_len(acc_msg.status);
  assign acc_first = rs_hit ? 2'd1 : 2'd0;
  assign tx_fire   = tx_valid & tx_ready;
  assign last_byte = (byte_idx == last_idx);

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] rs_q;

  assign rs_hit = midi_is_chan(acc_msg.status) && (acc_msg.status == rs_q);

  // Updated at accept: a reset mid-message clears RS anyway, so nothing is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs_q <= 8'h00;
    end else if (accept && acc_len != 2'd0) begin
      if (midi_is_chan(acc_msg.status)) begin
        rs_q <= acc_msg.status;
      end else if (acc_msg.status < MIDI_RT_LO) begin
        rs_q <= 8'h00;
      end
    end
  end
`else
  assign rs_hit = 1'b0;
`endif

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (accept && acc_len != 2'd0) state_d = ST_SEND;
      ST_SEND: if (tx_fire && last_byte) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d == ST_SEND);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      grant_id <= '0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= accept && (acc_len == 2'd0);
      if (accept) begin
        grant_id <= gnt_idx;
        rr_ptr   <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msg_q    <= '0;
      byte_idx <= 2'd0;
      last_idx <= 2'd0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (accept) begin
      if (acc_len != 2'd0) begin
        msg_q    <= acc_msg;
        byte_idx <= acc_first;
        last_idx <= acc_len - 2'd1;
        tx_valid <= 1'b1;
        tx_data  <= midi_msg_byte(acc_msg, acc_first);
      end
    end else if (tx_fire) begin
      if (last_byte) begin
        tx_valid <= 1'b0;
      end else begin
        byte_idx <= byte_idx + 2'd1;
        tx_data  <= midi_msg_byte(msg_q, byte_idx + 2'd1);
      end
    end
  end

endmodule

// File: tb/tb_midi_tx_scheduler.sv
// Scoreboard bench for midi_tx_scheduler: expected bytes and grants are queued at post
// time and popped by a negedge monitor on each tx handshake / accept.
module tb_midi_tx_scheduler;

  localparam int NUM_REQ = 4;

  logic                  clk;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [24*NUM_REQ-1:0] req_msg;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [7:0]            tx_data;
  logic                  busy;
  logic [1:0]            grant_id;
  logic                  drop_err;

  midi_tx_scheduler #(
    .NUM_REQ (NUM_REQ)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_msg   (req_msg),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .busy      (busy),
    .grant_id  (grant_id),
    .drop_err  (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_hs    = 0;
  int n_drop  = 0;
  int n_busy  = 0;
  logic [7:0] exp_q[$];
  int         gnt_q[$];
  logic [NUM_REQ-1:0] acc_mask = '0;
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] m_rs = 8'h00;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_len(input logic [7:0] s);
    if (s < 8'h80) return 0;
    if (s < 8'hC0) return 3;
    if (s < 8'hE0) return 2;
    if (s < 8'hF0) return 3;
    if (s == 8'hF2) return 3;
    if (s == 8'hF1 || s == 8'hF3) return 2;
    return 1;
  endfunction

  always @(negedge clk) begin
    acc_mask = req_valid & req_ready;
    if (reset_n) begin
      if (acc_mask != '0) begin
        chk("onehot", $countones(acc_mask), 1);
        if (gnt_q.size() == 0) begin
          chk("gnt_extra", gnt_q.size(), 1);
        end else begin
          int idx;
          idx = 0;
          for (int i = 0; i < NUM_REQ; i++) if (acc_mask[i]) idx = i;
          chk("gnt_order", idx, gnt_q.pop_front());
        end
      end
      if (tx_valid && tx_ready) begin
        n_hs++;
        if (exp_q.size() == 0) chk("tx_extra", exp_q.size(), 1);
        else chk("tx_byte", tx_data, exp_q.pop_front());
      end
      if (drop_err) n_drop++;
      if (busy) n_busy++;
      chk("busy_eq_vld", busy, tx_valid);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc_mask;
  endtask

  task automatic post(input int i, input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
    int   n;
    logic skip;
    n    = exp_len(s);
    skip = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
    if (n > 0) begin
      if (s >= 8'h80 && s < 8'hF0) begin
        skip = (s == m_rs);
        m_rs = s;
      end else if (s < 8'hF8) begin
        m_rs = 8'h00;
      end
    end
`endif
    if (n > 0 && !skip) exp_q.push_back(s);
    if (n >= 2) exp_q.push_back(d1 & 8'h7F);
    if (n == 3) exp_q.push_back(d2 & 8'h7F);
    req_msg[24*i +: 24] = {s, d1, d2};
    req_valid[i] = 1'b1;
    gnt_q.push_back(i);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && gnt_q.size() == 0 && !busy && req_valid == '0) break;
      step();
    end
    chk({tag, "_drain"}, exp_q.size() + gnt_q.size(), 0);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    exp_q.delete();
    gnt_q.delete();
`ifdef MIDI_RUNNING_STATUS_EN
    m_rs = 8'h00;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_hs(input int target, input string tag);
    for (int k = 0; k < 200; k++) begin
      if (n_hs >= target) break;
      step();
    end
    chk({tag, "_hs"}, n_hs, target);
  endtask

  initial begin
    int base_hs, base_drop, base_busy, changes;
    logic [7:0] held;
    reset_n   = 1'b0;
    req_valid = '0;
    req_msg   = '0;
    tx_ready  = 1'b0;
    #2;
    req_valid[0] = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_drop_err", drop_err, 0);
    do_reset();

    // Single request, tx_ready tied high.
    tx_ready  = 1'b1;
    base_busy = n_busy;
    post(0, 8'h90, 8'h3C, 8'h64);
    step();
    chk("lat_vld", tx_valid, 1);
    chk("lat_dat", tx_data, 8'h90);
    drain("single");
    chk("single_busy_cyc", n_busy - base_busy, 3);
    chk("single_gid", grant_id, 0);

    // Contention from rr_ptr=0, then a partial round.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) post(i, 8'hC0 | 8'(i), 8'(8'h10 + i), 8'h00);
    drain("cont4");
    chk("cont4_gid", grant_id, 3);
    post(1, 8'hC5, 8'h21, 8'h00);
    post(3, 8'hC7, 8'h23, 8'h00);
    drain("cont2");
    chk("cont2_gid", grant_id, 3);

    // Back-pressure mid-message.
    base_hs = n_hs;
    post(2, 8'hB0, 8'h07, 8'hFF);
    wait_hs(base_hs + 1, "bp_first");
    tx_ready = 1'b0;
    held     = tx_data;
    changes  = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (tx_data !== held || tx_valid !== 1'b1) changes++;
    end
    chk("bp_held_byte", held, 8'h07);
    chk("bp_stable", changes, 0);
    chk("bp_no_hs", n_hs - base_hs, 1);
    tx_ready = 1'b1;
    drain("bp");

    // tx_ready toggling while idle does nothing.
    base_hs = n_hs;
    for (int k = 0; k < 6; k++) begin
      tx_ready = ~tx_ready;
      step();
    end
    tx_ready = 1'b1;
    chk("idle_toggle", n_hs - base_hs, 0);

    // Invalid status is dropped, real-time status is one byte.
    base_hs   = n_hs;
    base_drop = n_drop;
    post(0, 8'h45, 8'h01, 8'h02);
    step();
    chk("drop_pulse", drop_err, 1);
    chk("drop_no_vld", tx_valid, 0);
    step();
    chk("drop_pulse_end", drop_err, 0);
    repeat (3) step();
    chk("drop_count", n_drop - base_drop, 1);
    chk("drop_no_bytes", n_hs - base_hs, 0);
    post(1, 8'hF8, 8'h55, 8'h66);
    drain("rt");
    chk("rt_bytes", n_hs - base_hs, 1);

    // Reset in the middle of a message.
    base_hs = n_hs;
    post(3, 8'h80, 8'h40, 8'h00);
    wait_hs(base_hs + 1, "rst_first");
    reset_n = 1'b0;
    #1;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_pending", exp_q.size(), 2);
    do_reset();
    base_hs = n_hs;
    repeat (3) step();
    chk("abort_silent", n_hs - base_hs, 0);
    post(1, 8'hE3, 8'h12, 8'h34);
    drain("post_rst");
    chk("post_rst_bytes", n_hs - base_hs, 3);

`ifdef MIDI_RUNNING_STATUS_EN
    do_reset();
    base_hs = n_hs;
    post(0, 8'h90, 8'h3C, 8'h64);
    drain("rs_a");
    post(0, 8'h90, 8'h3E, 8'h64);
    drain("rs_b");
    chk("rs_pair_bytes", n_hs - base_hs, 5);
    post(2, 8'hF8, 8'h00, 8'h00);
    drain("rs_rt");
    post(0, 8'h90, 8'h40, 8'h10);
    drain("rs_keep");
    post(2, 8'hF6, 8'h00, 8'h00);
    drain("rs_f6");
    post(0, 8'h90, 8'h41, 8'h11);
    drain("rs_resend");
    chk("rs_total_bytes", n_hs - base_hs, 5 + 1 + 2 + 1 + 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
